// File: rtl/mux_pipe_pkg.sv
// Shared constants and FSM state encoding for the mux_pipe channel selector.
package mux_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_IN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_pipe_mux_n.sv
// Combinational N:1 channel selector built as a one-hot AND-OR tree.
// Out-of-range selects fall back to channel 0 and are flagged on sel_oor.
module mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_oor
);

  localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

  logic [NUM_IN-1:0] hit_s;

  // Range check on the select, widened by one bit so NUM_IN itself is representable.
  always_comb begin
    sel_oor = ({1'b0, sel} >= NUM_IN_C);
  end

  // One-hot decode; channel 0 also absorbs out-of-range selects.
  always_comb begin
    hit_s = {NUM_IN{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      hit_s[k] = (sel == SEL_W'(k));
    end
    hit_s[0] = hit_s[0] | sel_oor;
  end

  // AND-OR merge of the decoded channel words.
  always_comb begin
    out_data = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      out_data = out_data | ({WIDTH{hit_s[k]}} & in_data[k*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 channel selector with a two-entry skid buffer (main, skid).
// Optional feature macro: MUX_PIPE_SELERR_EN (out-of-range select -> word 0 + sticky sel_err).
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  state_e             state_r;
  state_e             state_s;
  logic [WIDTH-1:0]   main_r;
  logic [WIDTH-1:0]   skid_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               sel_err_r;

  logic [WIDTH-1:0]   mux_word_s;
  logic [WIDTH-1:0]   word_s;
  logic               sel_oor_s;
  logic               accept_s;
  logic               emit_s;
  logic               load_main_new_s;
  logic               load_main_skid_s;
  logic               load_skid_s;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (mux_word_s),
    .sel_oor  (sel_oor_s)
  );

  assign accept_s  = in_valid & in_ready_r;
  assign emit_s    = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign sel_err   = sel_err_r;

`ifdef MUX_PIPE_SELERR_EN
  // Out-of-range selects store a zero word instead of channel 0.
  always_comb begin
    word_s = mux_word_s;
    if (sel_oor_s) begin
      word_s = {WIDTH{1'b0}};
    end else begin
      word_s = mux_word_s;
    end
  end

  // Sticky error flag; a new error on the acceptance edge beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else if (accept_s && sel_oor_s) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end
  end
`else
  logic unused_s;

  // Without the error feature the mux fallback (channel 0) is stored as-is.
  always_comb begin
    word_s = mux_word_s;
  end

  assign unused_s = err_clr ^ sel_oor_s;

  // Error flag is permanently clear in this build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= 1'b0;
    end
  end
`endif

  // Next-state and buffer load decisions for the skid buffer.
  always_comb begin
    state_s          = state_r;
    load_main_new_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s         = ONE;
          load_main_new_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && emit_s) begin
          state_s         = ONE;
          load_main_new_s = 1'b1;
        end else if (accept_s) begin
          state_s     = FULL;
          load_skid_s = 1'b1;
        end else if (emit_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (emit_s) begin
          state_s          = ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State plus the handshake flags, all derived from the next state so they stay register-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != FULL);
      out_valid_r <= (state_s != EMPTY);
    end
  end

  // Main holds the word on out_data; it only changes on an empty load or an emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= {WIDTH{1'b0}};
    end else if (load_main_new_s) begin
      main_r <= word_s;
    end else if (load_main_skid_s) begin
      main_r <= skid_r;
    end
  end

  // Skid catches the word accepted while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r <= {WIDTH{1'b0}};
    end else if (load_skid_s) begin
      skid_r <= word_s;
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Directed + scoreboard bench for mux_pipe (NUM_IN=4 main DUT, NUM_IN=3 DUT for range handling).
module tb_mux_pipe;

  localparam int W = 32;

`ifdef MUX_PIPE_SELERR_EN
  localparam bit SELERR = 1'b1;
`else
  localparam bit SELERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*W-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;
  logic          err_clr;

  logic [3*W-1:0] d3_in_data;
  logic [1:0]    d3_in_sel;
  logic          d3_in_valid;
  logic          d3_in_ready;
  logic [W-1:0]  d3_out_data;
  logic          d3_out_valid;
  logic          d3_out_ready;
  logic          d3_sel_err;
  logic          d3_err_clr;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_emit = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_word = '0;

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(W), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .err_clr(err_clr)
  );

  mux_pipe #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .sel_err(d3_sel_err),
    .err_clr(d3_err_clr)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) in_data[k*W +: W] = $urandom;
  endtask

  // Scoreboard monitor: handshakes resolved at the negedge before the edge that completes them.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) chk("stall_hold", out_data, stall_word);
        if (out_valid && out_ready) begin
          n_emit++;
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            chk("sb_order", out_data, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          n_acc++;
          exp_q.push_back(in_data[in_sel*W +: W]);
        end
        stall_prev = out_valid && !out_ready;
        stall_word = out_data;
      end
    end
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_emit;
    int guard;
    rst_n = 1'b0; in_data = '0; in_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    d3_in_data = '0; d3_in_sel = 2'd0; d3_in_valid = 1'b0; d3_out_ready = 1'b1; d3_err_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("rel_in_ready_rise", {31'd0, in_ready}, 32'd1);

    // Single transfer, latency 1
    rand_data();
    in_data[2*W +: W] = 32'hA5A5_A5A5;
    in_sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    rand_data();
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data", out_data, 32'hA5A5_A5A5);
    cyc();
    chk("lat_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure fills both entries
    out_ready = 1'b0;
    rand_data(); in_data[0 +: W] = 32'h1111_0000; in_sel = 2'd0; in_valid = 1'b1;
    cyc();
    rand_data(); in_data[1*W +: W] = 32'h2222_0001; in_sel = 2'd1;
    cyc();
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_hold0", out_data, 32'h1111_0000);
    rand_data(); in_data[3*W +: W] = 32'h3333_0003; in_sel = 2'd3;
    cyc();
    chk("bp_in_ready_cyc3", {31'd0, in_ready}, 32'd0);
    chk("bp_hold1", out_data, 32'h1111_0000);
    out_ready = 1'b1;
    cyc();
    chk("bp_skid_to_main", out_data, 32'h2222_0001);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_third", out_data, 32'h3333_0003);
    cyc();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Full-throughput streaming
    base_emit = n_emit;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_data();
      in_sel = 2'(i % 4);
      cyc();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_count", n_emit - base_emit, 32'd16);
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // Out-of-range select on the NUM_IN=3 instance
    d3_in_data = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    d3_in_sel = 2'd3; d3_in_valid = 1'b1;
    cyc();
    d3_in_valid = 1'b0;
    chk("oor_valid", {31'd0, d3_out_valid}, 32'd1);
    chk("oor_data", d3_out_data, SELERR ? 32'd0 : 32'hC0C0_C0C0);
    chk("oor_err_set", {31'd0, d3_sel_err}, {31'd0, SELERR});
    cyc();
    chk("oor_err_sticky", {31'd0, d3_sel_err}, {31'd0, SELERR});
    d3_err_clr = 1'b1;
    cyc();
    d3_err_clr = 1'b0;
    chk("oor_err_clr", {31'd0, d3_sel_err}, 32'd0);
    d3_in_sel = 2'd3; d3_in_valid = 1'b1; d3_err_clr = 1'b1;
    cyc();
    d3_in_valid = 1'b0; d3_err_clr = 1'b0;
    chk("oor_set_wins", {31'd0, d3_sel_err}, {31'd0, SELERR});
    d3_err_clr = 1'b1;
    cyc();
    d3_err_clr = 1'b0;
    d3_in_sel = 2'd2; d3_in_valid = 1'b1;
    cyc();
    d3_in_valid = 1'b0;
    chk("inrange_data", d3_out_data, 32'hC2C2_C2C2);
    chk("inrange_no_err", {31'd0, d3_sel_err}, 32'd0);

    // Async reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    rand_data(); in_sel = 2'd1;
    cyc();
    rand_data(); in_sel = 2'd2;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_out_data", out_data, 32'd0);
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

    // Random backpressure, 200 transfers
    n_acc = 0;
    guard = 0;
    while (n_acc < 200 && guard < 4000) begin
      rand_data();
      in_sel = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      cyc();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_accepted", n_acc, 32'd200);
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      cyc();
      guard++;
    end
    chk("rand_drained", exp_q.size(), 32'd0);
    cyc();
    chk("rand_final_empty", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of each channel.
REQ-002 SHALL have parameter NUM_IN, default 4, range 2..16, meaning the number of input channels.
REQ-003 SHALL have derived parameter SEL_W, default clog2(NUM_IN), minimum 1, meaning the select width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, NUM_IN*WIDTH, the flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_sel, input, SEL_W, the channel select, qualified by in_valid.
REQ-008 SHALL have port in_valid, input, 1, meaning upstream offers in_data/in_sel.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts this cycle.
REQ-010 SHALL have port out_data, output, WIDTH, the selected channel, registered.
REQ-011 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-013 SHALL have port sel_err, output, 1, a sticky out-of-range select flag.
REQ-014 SHALL have port err_clr, input, 1, a synchronous clear for sel_err.

Function
REQ-015 SHALL accept a transfer when in_valid && in_ready, and emit it when out_valid && out_ready.
REQ-016 SHALL latch the selected channel word (not the index) at acceptance; later in_data changes do not affect stored words.
REQ-017 SHALL have latency of exactly 1 cycle from acceptance to out_valid when empty.
REQ-018 SHALL use a 2-entry skid buffer (main, skid) with states EMPTY, ONE, FULL.
REQ-019 SHALL drive in_ready = (state != FULL) as a register-only function, with no combinational path from out_ready.
REQ-020 SHALL make the following transitions: EMPTY + accept -> ONE; ONE + accept without emit -> FULL; ONE + emit without accept -> EMPTY; FULL + emit -> ONE (skid moves to main); otherwise hold.
REQ-021 SHALL, when in ONE with simultaneous accept and emit, stay in ONE with main loaded with the new word, achieving 1 word/cycle throughput.
REQ-022 SHALL preserve order: FIFO order, no drops, no duplicates.
REQ-023 SHALL keep out_data stable while out_valid && !out_ready.
REQ-024 SHALL treat in_sel >= NUM_IN (non-power-of-2 NUM_IN) as out of range; handling is per the Configuration section.

Reset
REQ-025 SHALL on rst_n low, asynchronously, set state to EMPTY, out_valid 0, out_data 0, sel_err 0, and in_ready 0 while reset is asserted.
REQ-026 SHALL, on reset mid-operation, discard buffered words, and in_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro MUX_PIPE_SELERR_EN defined, on an out-of-range accepted select, store word 0 and set sel_err on the acceptance edge; sel_err holds until err_clr; set wins over a same-cycle err_clr.
REQ-028 SHALL, without MUX_PIPE_SELERR_EN, on an out-of-range select, store channel 0; sel_err is tied 0 and err_clr is ignored.

Structure
REQ-029 SHALL place the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default WIDTH/NUM_IN constants in shared package mux_pipe_pkg.
REQ-030 SHALL implement the combinational N:1 selection as sub-module mux_n (parametrised WIDTH, NUM_IN), generalising the existing 2:1 muxes; mux_pipe holds all state.

Verification
REQ-031 SHALL cover: reset, then one accept with sel=2 and channel2=0xA5A5A5A5, out_ready=1 -> out_valid next cycle with out_data=0xA5A5A5A5, then EMPTY.
REQ-032 SHALL cover: out_ready=0, three words offered (sel 0,1,3) -> two accepted, in_ready=0 on cycle 3; release out_ready -> outputs ch0, ch1 words in order; third accepted after in_ready rises.
REQ-033 SHALL cover: continuous in_valid=1, out_ready=1 for 16 cycles, rotating sel -> 16 outputs, one per cycle, in_ready constant 1.
REQ-034 SHALL cover: NUM_IN=3, sel=3 with macro defined -> out_data=0, sel_err=1 until err_clr pulse; without macro -> out_data=channel0, sel_err=0.
REQ-035 SHALL cover: rst_n pulsed low while FULL -> out_valid=0 immediately (asynchronous), no stale word after release.
REQ-036 SHALL cover: out_ready toggled randomly for 200 transfers -> scoreboard order match, out_data stable during stalls.
